// File: rtl/hpdl_bus_monitor.sv
// hpdl_bus_monitor
// Snoops writes to four HPDL-style 4-digit displays, mirrors the 16 digits in
// a local buffer and streams the buffer to a byte transmitter as a 17-byte
// frame (0x0D followed by the 16 entries).
//
// Ports
//   CLK, RST_N    system clock, asynchronous active-low reset
//   HPDL_D[6:0]   display data bus (asynchronous to CLK)
//   HPDL_A[1:0]   digit address within a display (asynchronous)
//   HPDL_WR_N[3:0] active-low write strobes, bit k = display k (asynchronous)
//   DUMP_REQ      level-sampled frame request
//   TX_BUSY       transmitter busy flag
//   TX_DATA[7:0]  byte presented to the transmitter
//   TX_START      one-cycle start pulse
//   FRAME_ACTIVE  high while a frame is in progress
//   WR_ERR        one-cycle pulse on a colliding write
//   WR_COUNT[7:0] accepted write count, saturating at 255
module hpdl_bus_monitor #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          ADDR_INV    = 1'b1,
  parameter bit          AUTO_DUMP   = 1'b1
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [6:0] HPDL_D,
  input  logic [1:0] HPDL_A,
  input  logic [3:0] HPDL_WR_N,
  input  logic       DUMP_REQ,
  input  logic       TX_BUSY,
  output logic [7:0] TX_DATA,
  output logic       TX_START,
  output logic       FRAME_ACTIVE,
  output logic       WR_ERR,
  output logic [7:0] WR_COUNT
);

  // Strobes idle high, data/address idle low.
  localparam logic [12:0] SYNC_RST = {4'hF, 2'b00, 7'h00};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_ACK,
    ST_DRAIN
  } state_t;

  logic [SYNC_STAGES-1:0][12:0] sync_q;
  logic [12:0] sync_o;
  logic [3:0]  wr_n_s, wr_n_p;
  logic [1:0]  a_s, a_p, digit;
  logic [6:0]  d_s, d_p;
  logic [3:0]  rise;
  logic [2:0]  n_rise;
  logic [1:0]  disp;
  logic        wr_one, wr_coll;

  logic [6:0]  mem [16];

  state_t      state;
  logic [4:0]  idx, idx_m1;
  logic [1:0]  ack_cnt;
  logic        pend, dirty, launch;

  // Input synchronizers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_q <= {SYNC_STAGES{SYNC_RST}};
    end else begin
      sync_q[0] <= {HPDL_WR_N, HPDL_A, HPDL_D};
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];
  assign wr_n_s = sync_o[12:9];
  assign a_s    = sync_o[8:7];
  assign d_s    = sync_o[6:0];

  // A write completes on the strobe's rising edge; data/address come from the
  // last cycle the strobe was still low.
  assign rise  = wr_n_s & ~wr_n_p;
  assign digit = ADDR_INV ? ~a_p : a_p;

  always_comb begin
    n_rise = '0;
    disp   = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (rise[k]) begin
        n_rise = n_rise + 3'd1;
        disp   = 2'(k);
      end
    end
  end

  assign wr_one  = (n_rise == 3'd1);
  assign wr_coll = (n_rise >= 3'd2);

  // Write capture, buffer and statistics
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_n_p   <= '1;
      a_p      <= '0;
      d_p      <= '0;
      WR_ERR   <= 1'b0;
      WR_COUNT <= '0;
      for (int unsigned i = 0; i < 16; i++) begin
        mem[i] <= 7'h20;
      end
    end else begin
      wr_n_p <= wr_n_s;
      a_p    <= a_s;
      d_p    <= d_s;
      WR_ERR <= wr_coll;
      if (wr_one) begin
        mem[{disp, digit}] <= d_p;
        if (WR_COUNT != 8'hFF) begin
          WR_COUNT <= WR_COUNT + 8'd1;
        end
      end
    end
  end

  // Frame engine
  assign launch = (state == ST_IDLE) && (pend || (AUTO_DUMP && dirty));
  assign idx_m1 = idx - 5'd1;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state        <= ST_IDLE;
      idx          <= '0;
      ack_cnt      <= '0;
      pend         <= 1'b0;
      dirty        <= 1'b0;
      TX_DATA      <= '0;
      TX_START     <= 1'b0;
      FRAME_ACTIVE <= 1'b0;
    end else begin
      TX_START <= 1'b0;
      // Launch clears both flags; an event in the same cycle re-arms them so
      // it is never lost.
      pend  <= DUMP_REQ || (pend && !launch);
      dirty <= (AUTO_DUMP && wr_one) || (dirty && !launch);

      unique case (state)
        ST_IDLE: begin
          if (launch) begin
            state        <= ST_LOAD;
            idx          <= '0;
            FRAME_ACTIVE <= 1'b1;
          end
        end
        ST_LOAD: begin
          TX_DATA <= (idx == 5'd0) ? 8'h0D : {1'b0, mem[idx_m1[3:0]]};
          state   <= ST_START;
        end
        ST_START: begin
          if (!TX_BUSY) begin
            TX_START <= 1'b1;
            ack_cnt  <= '0;
            state    <= ST_ACK;
          end
        end
        ST_ACK: begin
          // Fourth idle cycle without BUSY counts the byte as sent.
          if (TX_BUSY || ack_cnt == 2'd3) begin
            state <= ST_DRAIN;
          end else begin
            ack_cnt <= ack_cnt + 2'd1;
          end
        end
        ST_DRAIN: begin
          if (!TX_BUSY) begin
            idx <= idx + 5'd1;
            if (idx == 5'd16) begin
              state        <= ST_IDLE;
              FRAME_ACTIVE <= 1'b0;
            end else begin
              state <= ST_LOAD;
            end
          end
        end
        default: begin
          state        <= ST_IDLE;
          FRAME_ACTIVE <= 1'b0;
        end
      endcase
    end
  end

endmodule
